dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
//
// PURPOSE
//   Data-memory responder (target side) for the core's mem_* request interface.
//   Accepts one read or write request at a time and completes it after a fixed
//   LATENCY with a one-cycle mem_ready pulse. Backed by a word-wide array with
//   byte-strobe writes.
//   Sits between the core's load/store path and memory, replacing zero-latency
//   memory so that stall handling in the core can be exercised.
//
// PARAMETERS
//   ADDR_WIDTH  32     byte-address width
//   DATA_WIDTH  32     data width; DATA_WIDTH/8 strobe bits
//   DEPTH       1024   number of words in the array (power of 2)
//   BASE_ADDR   0      byte address of word 0; legal range is BASE_ADDR .. BASE_ADDR+DEPTH*4-1
//   LATENCY     2      cycles from accept to mem_ready; legal range 1..15 (elaboration error otherwise)
//
// PORTS
//   clk        in   1             clock; all logic on posedge
//   rst        in   1             synchronous reset, active-high
//   mem_addr   in   ADDR_WIDTH    byte address; bits [1:0] ignored (word access)
//   mem_wdata  in   DATA_WIDTH    write data, already lane-aligned by the initiator
//   mem_wstrb  in   DATA_WIDTH/8  byte-lane write enables
//   mem_write  in   1             write request
//   mem_read   in   1             read request
//   mem_rdata  out  DATA_WIDTH    full aligned word; valid only while mem_ready=1, else 0
//   mem_ready  out  1             one-cycle completion pulse
//   mem_err    out  1             with mem_ready: request out of range or read+write conflict
//
// BEHAVIOUR
//   - Reset: state=IDLE, mem_ready=0, mem_err=0, mem_rdata=0, counter=0.
//     Array contents are NOT cleared by reset.
//   - FSM states:
//     - IDLE: on (mem_read|mem_write), latch addr/wdata/wstrb/kind and load
//       cnt=LATENCY-1. Next state is WAIT if cnt>0, else RESP.
//     - WAIT: decrement cnt; go to RESP when cnt==0 at the clock edge.
//     - RESP: mem_ready=1 for exactly this cycle, then IDLE.
//   - Timing: request sampled in cycle 0 -> mem_ready high in cycle LATENCY.
//     Registered outputs only; no combinational input->output paths.
//   - Commit: on the edge entering RESP.
//     - Write updates only the byte lanes with wstrb=1.
//     - Read registers array[word] into mem_rdata.
//     - wstrb=0 write completes normally with no array change.
//   - Initiator contract: hold the request stable until mem_ready. The
//     responder uses the latched copy; input changes after accept are ignored.
//   - Back-to-back: the request present during the RESP cycle is NOT accepted.
//     The next accept is in the following IDLE cycle, so peak throughput is
//     1 request per LATENCY+1 cycles.
//   - Read-after-write to the same word returns the newly written data.
//   - Out of range (addr < BASE_ADDR or addr >= BASE_ADDR+DEPTH*4):
//     no array access, mem_rdata=0, mem_err=1 with mem_ready.
//   - mem_read and mem_write both high at accept: treated as a write if in
//     range, and mem_err=1 with mem_ready.
//   - Address arithmetic: offset = mem_addr - BASE_ADDR (unsigned, ADDR_WIDTH);
//     word index = offset[2 +: $clog2(DEPTH)].
//   - rst high mid-transaction: abort to IDLE next edge, no mem_ready pulse.
//     A write already committed stays; an uncommitted write is dropped.
//
// TESTING
//   1. LATENCY=2, write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> ready in
//      cycle 2, err=0. Then read 0x10 -> rdata 0xDEADBEEF in the ready cycle.
//   2. Over word 0x10=0xDEADBEEF, write wdata 0x0000AA00, wstrb 4'b0010 ->
//      read returns 0xDEADAAEF.
//   3. Read 0x1000 with DEPTH=1024, BASE_ADDR=0 -> ready with err=1, rdata=0,
//      array unchanged.
//   4. Request held high continuously -> ready pulses every LATENCY+1 cycles
//      (every 3 for LATENCY=2), never 2 consecutive cycles.
//   5. rst asserted in WAIT of a write to 0x20 -> no ready pulse, state IDLE,
//      word 0x20 unchanged on subsequent read.
//   6. LATENCY=1 sweep: read/write both high at 0x4 -> treated as write, ready
//      in cycle 1 with err=1, word 0x4 updated.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, completed after LATENCY cycles with a one-cycle mem_ready pulse.
// No accept while busy or during the RESP cycle; the initiator holds its request until mem_ready.
module dmem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_write,
  input  logic                    mem_read,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ready,
  output logic                    mem_err
);

  localparam int                  STRB_W   = DATA_WIDTH / 8;
  localparam int                  IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH + 1)'(DEPTH * 4);
  localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    is_wr_q, is_wr_d;
  logic                    conflict_q, conflict_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]   mem_array [DEPTH];

  logic                    commit;
  logic [ADDR_WIDTH-1:0]   txn_addr;
  logic [DATA_WIDTH-1:0]   txn_wdata;
  logic [STRB_W-1:0]       txn_wstrb;
  logic                    txn_wr;
  logic                    txn_conflict;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_range;
  logic [IDX_W-1:0]        word_idx;
  logic                    wr_en;

  // With LATENCY=1 the commit edge is the accept edge, so the live inputs stand in for the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      txn_addr     = mem_addr;
      txn_wdata    = mem_wdata;
      txn_wstrb    = mem_wstrb;
      txn_wr       = mem_write;
      txn_conflict = mem_read & mem_write;
    end else begin
      txn_addr     = addr_q;
      txn_wdata    = wdata_q;
      txn_wstrb    = wstrb_q;
      txn_wr       = is_wr_q;
      txn_conflict = conflict_q;
    end
    offset   = txn_addr - BASE_ADDR;
    in_range = ({1'b0, txn_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, offset} < SPAN);
    word_idx = offset[2 +: IDX_W];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    is_wr_d    = is_wr_q;
    conflict_d = conflict_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wstrb_d    = mem_wstrb;
          is_wr_d    = mem_write;
          conflict_d = mem_read & mem_write;
          cnt_d      = CNT_INIT;
          if (CNT_INIT != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_en   = commit && txn_wr && in_range;
    ready_d = commit;
    err_d   = commit && (!in_range || txn_conflict);
    rdata_d = (commit && !txn_wr && in_range) ? mem_array[word_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      is_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      is_wr_q    <= is_wr_d;
      conflict_q <= conflict_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is deliberately not cleared by reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (txn_wstrb[b]) begin
          mem_array[word_idx][8*b +: 8] <= txn_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance share one request bus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(rdata0), .mem_ready(rdy0), .mem_err(err0)
  );

  dmem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(rdata1), .mem_ready(rdy1), .mem_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for ready on the selected instance, then drop the request.
  task automatic req(input int sel, input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output int lat, output logic e, output logic [31:0] q);
    @(negedge clk);
    mem_write = w; mem_read = r; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    lat = -1; e = 1'b0; q = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? rdy0 : rdy1) begin
        lat = n;
        e   = (sel == 0) ? err0 : err1;
        q   = (sel == 0) ? rdata0 : rdata1;
        break;
      end
    end
    mem_write = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", (sel == 0) ? rdy0 : rdy1, 32'd0);
    check("rdata_zero_idle", (sel == 0) ? rdata0 : rdata1, 32'd0);
  endtask

  int          lat;
  logic        e;
  logic [31:0] q;

  initial begin
    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; mem_write = 1'b0; mem_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", rdy0, 32'd0);
    check("reset_err", err0, 32'd0);
    check("reset_rdata", rdata0, 32'd0);
    check("reset_ready_l1", rdy1, 32'd0);
    rst = 1'b0;

    // full write then read back
    req(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, lat, e, q);
    check("wr_latency", lat, 32'd2);
    check("wr_err", e, 32'd0);
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, e, q);
    check("rd_latency", lat, 32'd2);
    check("rd_data", q, 32'hDEADBEEF);
    check("rd_err", e, 32'd0);

    // single byte lane, then an all-lanes-off write that must leave the word alone
    req(0, 1, 0, 32'h10, 32'h0000AA00, 4'b0010, lat, e, q);
    check("strb_wr_err", e, 32'd0);
    req(0, 1, 0, 32'h10, 32'h55555555, 4'b0000, lat, e, q);
    check("strb0_latency", lat, 32'd2);
    check("strb0_err", e, 32'd0);
    req(0, 0, 1, 32'h13, 32'h0, 4'h0, lat, e, q);
    check("strb_rd_data", q, 32'hDEADAAEF);

    // out of range: error, zero data, no aliasing onto word 0
    req(0, 1, 0, 32'h0, 32'h11112222, 4'hF, lat, e, q);
    req(0, 0, 1, 32'h1000, 32'h0, 4'h0, lat, e, q);
    check("oor_rd_latency", lat, 32'd2);
    check("oor_rd_err", e, 32'd1);
    check("oor_rd_data", q, 32'd0);
    req(0, 1, 0, 32'h1000, 32'h99999999, 4'hF, lat, e, q);
    check("oor_wr_err", e, 32'd1);
    req(0, 0, 1, 32'hFFC, 32'h0, 4'h0, lat, e, q);
    check("last_word_err", e, 32'd0);
    req(0, 0, 1, 32'h0, 32'h0, 4'h0, lat, e, q);
    check("oor_no_alias", q, 32'h11112222);

    // request held continuously: ready on every third edge only
    @(negedge clk);
    mem_read = 1'b1; mem_addr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check("hold_ready", rdy0, (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) check("hold_rdata", rdata0, 32'hDEADAAEF);
    end
    mem_read = 1'b0;
    repeat (3) @(posedge clk);

    // reset during WAIT of a write drops it
    req(0, 1, 0, 32'h20, 32'hCAFEF00D, 4'hF, lat, e, q);
    @(negedge clk);
    mem_write = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    check("rst_no_ready", rdy0, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_quiet", rdy0, 32'd0);
    end
    req(0, 0, 1, 32'h20, 32'h0, 4'h0, lat, e, q);
    check("rst_idle_latency", lat, 32'd2);
    check("rst_word_kept", q, 32'hCAFEF00D);

    // LATENCY=1: read+write conflict is a write with error
    repeat (3) @(posedge clk);
    req(1, 1, 1, 32'h4, 32'hA5A5A5A5, 4'hF, lat, e, q);
    check("l1_conf_latency", lat, 32'd1);
    check("l1_conf_err", e, 32'd1);
    repeat (3) @(posedge clk);
    req(1, 0, 1, 32'h4, 32'h0, 4'h0, lat, e, q);
    check("l1_rd_latency", lat, 32'd1);
    check("l1_rd_err", e, 32'd0);
    check("l1_rd_data", q, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
